// File: rtl/hazard_tracker_if.sv
// hazard_tracker_if: D-stage hazard inputs and forwarding/stall outputs of the hazard tracker
//   master drives D_* instruction info and observes the forwarding/stall outputs;
//   slave (hazard_tracker) consumes D_* and drives A3_*/*_W/Tnew_*/stall/E_clr/md_busy.
interface hazard_tracker_if;
  logic [4:0] D_A1;
  logic [4:0] D_A2;
  logic       D_use_rs;
  logic       D_use_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic [4:0] D_A3;
  logic       D_W;
  logic [1:0] D_Tnew;
  logic       D_md_start;
  logic       D_md_div;
  logic       D_md_use;
  logic [4:0] A3_E;
  logic [4:0] A3_M;
  logic [4:0] A3_W;
  logic       E_W;
  logic       M_W;
  logic       W_W;
  logic [1:0] Tnew_E;
  logic [1:0] Tnew_M;
  logic       stall;
  logic       E_clr;
  logic       md_busy;
  modport master (
    output D_A1, D_A2, D_use_rs, D_use_rt, D_Tuse_rs, D_Tuse_rt,
           D_A3, D_W, D_Tnew, D_md_start, D_md_div, D_md_use,
    input  A3_E, A3_M, A3_W, E_W, M_W, W_W, Tnew_E, Tnew_M, stall, E_clr, md_busy
  );
  modport slave (
    input  D_A1, D_A2, D_use_rs, D_use_rt, D_Tuse_rs, D_Tuse_rt,
           D_A3, D_W, D_Tnew, D_md_start, D_md_div, D_md_use,
    output A3_E, A3_M, A3_W, E_W, M_W, W_W, Tnew_E, Tnew_M, stall, E_clr, md_busy
  );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks E/M/W destination tags and Tnew, generates stall/E-bubble and md busy
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   hif   - hazard_tracker_if.slave: D-stage instruction info in, forwarding tags/stall out
module hazard_tracker #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic             clk,
  input logic             reset,
  hazard_tracker_if.slave hif
);
  logic [4:0] a3_e_q, a3_e_d, a3_m_q, a3_m_d, a3_w_q, a3_w_d;
  logic       e_w_q, e_w_d, m_w_q, m_w_d, w_w_q, w_w_d;
  logic [1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
  logic       md_pend_q, md_pend_d, md_div_q, md_div_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       haz_rs, haz_rt, haz_md, stall;
  always_comb begin
    haz_rs = hif.D_use_rs && hif.D_A1 != 5'd0 &&
             ((hif.D_A1 == a3_e_q && e_w_q && tnew_e_q > hif.D_Tuse_rs) ||
              (hif.D_A1 == a3_m_q && m_w_q && tnew_m_q > hif.D_Tuse_rs));
    haz_rt = hif.D_use_rt && hif.D_A2 != 5'd0 &&
             ((hif.D_A2 == a3_e_q && e_w_q && tnew_e_q > hif.D_Tuse_rt) ||
              (hif.D_A2 == a3_m_q && m_w_q && tnew_m_q > hif.D_Tuse_rt));
    // A start still sitting in E has not loaded the counter yet, so it counts as busy too
    haz_md = hif.D_md_use && (md_cnt_q != 4'd0 || md_pend_q);
    stall  = haz_rs || haz_rt || haz_md;
    a3_w_d    = a3_m_q;
    w_w_d     = m_w_q;
    a3_m_d    = a3_e_q;
    m_w_d     = e_w_q;
    tnew_m_d  = tnew_e_q == 2'd0 ? 2'd0 : tnew_e_q - 2'd1;
    a3_e_d    = stall ? 5'd0 : hif.D_A3;
    e_w_d     = stall ? 1'b0 : hif.D_W;
    tnew_e_d  = stall ? 2'd0 : hif.D_Tnew;
    md_pend_d = !stall && hif.D_md_start;
    md_div_d  = !stall && hif.D_md_start && hif.D_md_div;
    md_cnt_d  = md_pend_q ? (md_div_q ? 4'(DIV_LAT) : 4'(MULT_LAT)) :
                md_cnt_q != 4'd0 ? md_cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e_q    <= 5'd0;
      a3_m_q    <= 5'd0;
      a3_w_q    <= 5'd0;
      e_w_q     <= 1'b0;
      m_w_q     <= 1'b0;
      w_w_q     <= 1'b0;
      tnew_e_q  <= 2'd0;
      tnew_m_q  <= 2'd0;
      md_pend_q <= 1'b0;
      md_div_q  <= 1'b0;
      md_cnt_q  <= 4'd0;
    end else begin
      a3_e_q    <= a3_e_d;
      a3_m_q    <= a3_m_d;
      a3_w_q    <= a3_w_d;
      e_w_q     <= e_w_d;
      m_w_q     <= m_w_d;
      w_w_q     <= w_w_d;
      tnew_e_q  <= tnew_e_d;
      tnew_m_q  <= tnew_m_d;
      md_pend_q <= md_pend_d;
      md_div_q  <= md_div_d;
      md_cnt_q  <= md_cnt_d;
    end
  end
  assign hif.A3_E    = a3_e_q;
  assign hif.A3_M    = a3_m_q;
  assign hif.A3_W    = a3_w_q;
  assign hif.E_W     = e_w_q;
  assign hif.M_W     = m_w_q;
  assign hif.W_W     = w_w_q;
  assign hif.Tnew_E  = tnew_e_q;
  assign hif.Tnew_M  = tnew_m_q;
  assign hif.stall   = stall;
  assign hif.E_clr   = stall;
  assign hif.md_busy = md_cnt_q != 4'd0;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed self-checking bench for hazard_tracker
module tb_hazard_tracker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  int n, b;
  hazard_tracker_if hif ();
  hazard_tracker dut (.clk(clk), .reset(reset), .hif(hif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic d_set(input logic [4:0] a1, input logic ur, input logic [1:0] tur,
                       input logic [4:0] a2, input logic ut, input logic [1:0] tut,
                       input logic [4:0] a3, input logic w, input logic [1:0] tnew,
                       input logic mds, input logic mdd, input logic mdu);
    hif.D_A1 = a1; hif.D_use_rs = ur; hif.D_Tuse_rs = tur;
    hif.D_A2 = a2; hif.D_use_rt = ut; hif.D_Tuse_rt = tut;
    hif.D_A3 = a3; hif.D_W = w; hif.D_Tnew = tnew;
    hif.D_md_start = mds; hif.D_md_div = mdd; hif.D_md_use = mdu;
    #1;
  endtask
  task automatic nop();
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic md_run(input logic div, input int exp_stall, input int exp_busy, input string tag);
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, div, 1);
    tick();
    d_set(0, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1);
    n = 0;
    b = 0;
    for (int i = 0; i < 30; i++) begin
      if (!hif.stall) break;
      n++;
      if (hif.md_busy) b++;
      tick();
      #1;
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_busy_cycles"}, b, exp_busy);
    tick();
    chk({tag, "_mfhi_in_E"}, hif.A3_E, 12);
    nop();
  endtask
  initial begin
    nop();
    #2;
    chk("rst_stall", hif.stall, 0);
    chk("rst_A3_E", hif.A3_E, 0);
    chk("rst_Tnew_E", hif.Tnew_E, 0);
    chk("rst_md_busy", hif.md_busy, 0);
    #5 reset = 1'b1;
    tick();
    // load-use
    d_set(29, 1, 1, 0, 0, 0, 8, 1, 2, 0, 0, 0);
    chk("lw_no_stall", hif.stall, 0);
    tick();
    d_set(8, 1, 1, 9, 1, 1, 10, 1, 1, 0, 0, 0);
    chk("lu_A3_E", hif.A3_E, 8);
    chk("lu_Tnew_E", hif.Tnew_E, 2);
    chk("lu_stall", hif.stall, 1);
    chk("lu_E_clr", hif.E_clr, 1);
    tick();
    #1;
    chk("lu_bubble_A3_E", hif.A3_E, 0);
    chk("lu_bubble_E_W", hif.E_W, 0);
    chk("lu_A3_M", hif.A3_M, 8);
    chk("lu_Tnew_M", hif.Tnew_M, 1);
    chk("lu_stall_released", hif.stall, 0);
    tick();
    nop();
    chk("lu_addu_A3_E", hif.A3_E, 10);
    chk("lu_A3_W", hif.A3_W, 8);
    chk("lu_W_W", hif.W_W, 1);
    tick();
    // ALU chain
    d_set(0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    chk("alu1_stall", hif.stall, 0);
    tick();
    d_set(5, 1, 1, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    chk("alu2_stall", hif.stall, 0);
    chk("alu2_A3_E", hif.A3_E, 5);
    chk("alu2_Tnew_E", hif.Tnew_E, 1);
    tick();
    nop();
    chk("alu_A3_M", hif.A3_M, 5);
    chk("alu_Tnew_M", hif.Tnew_M, 0);
    chk("alu_A3_E", hif.A3_E, 6);
    tick();
    chk("alu_A3_W", hif.A3_W, 5);
    // branch on ALU result
    d_set(0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    tick();
    d_set(5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_stall", hif.stall, 1);
    tick();
    #1;
    chk("beq_stall_released", hif.stall, 0);
    chk("beq_Tnew_M", hif.Tnew_M, 0);
    chk("beq_A3_M", hif.A3_M, 5);
    tick();
    nop();
    // $0 and jal
    d_set(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    tick();
    d_set(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0);
    chk("zero_no_stall", hif.stall, 0);
    tick();
    d_set(0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0);
    tick();
    d_set(31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("jal_A3_E", hif.A3_E, 31);
    chk("jal_Tnew_E", hif.Tnew_E, 0);
    chk("jal_no_stall", hif.stall, 0);
    tick();
    nop();
    tick();
    tick();
    // mult / div latency
    md_run(1'b0, 6, 5, "mult");
    tick();
    tick();
    md_run(1'b1, 11, 10, "div");
    tick();
    tick();
    // reset mid-operation
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    d_set(29, 1, 1, 0, 0, 0, 8, 1, 2, 0, 0, 0);
    tick();
    d_set(8, 1, 1, 0, 0, 0, 10, 1, 1, 0, 0, 0);
    chk("mid_stall", hif.stall, 1);
    chk("mid_md_busy", hif.md_busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", hif.stall, 0);
    chk("mid_rst_md_busy", hif.md_busy, 0);
    chk("mid_rst_A3_E", hif.A3_E, 0);
    chk("mid_rst_A3_M", hif.A3_M, 0);
    chk("mid_rst_E_W", hif.E_W, 0);
    chk("mid_rst_M_W", hif.M_W, 0);
    chk("mid_rst_Tnew_E", hif.Tnew_E, 0);
    chk("mid_rst_Tnew_M", hif.Tnew_M, 0);
    nop();
    #1 reset = 1'b1;
    tick();
    chk("post_rst_stall", hif.stall, 0);
    chk("post_rst_A3_E", hif.A3_E, 0);
    chk("post_rst_md_busy", hif.md_busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the pipeline forwarding interface for the 5-stage CPU.
- Holds the destination tag, write-enable and remaining-latency (Tnew) of the instructions in E, M and W, and advances them each cycle.
- Drives the A3/Tnew/write-enable signals that the forwarding unit consumes.
- Compares Tuse of the instruction in D against in-flight Tnew, and tracks mult/div busy time, to generate stall and E-bubble.

Parameters:
MULT_LAT  5   cycles the mult unit stays busy after a mult/multu enters E
DIV_LAT   10  cycles the div unit stays busy after a div/divu enters E

Ports:
clk         in   1  clock, rising edge
reset       in   1  asynchronous, active-low reset
D_A1        in   5  rs index of instruction in D
D_A2        in   5  rt index of instruction in D
D_use_rs    in   1  D instruction reads rs
D_use_rt    in   1  D instruction reads rt
D_Tuse_rs   in   2  cycles after D before rs value is needed
D_Tuse_rt   in   2  cycles after D before rt value is needed
D_A3        in   5  destination register of D instruction
D_W         in   1  D instruction writes GRF
D_Tnew      in   2  Tnew the instruction carries on entering E
D_md_start  in   1  D instruction is mult/multu (1) or div/divu (see D_md_div)
D_md_div    in   1  qualifies D_md_start: 1 = div, 0 = mult
D_md_use    in   1  D instruction needs HI/LO or the md unit (mf*/mt*/mult/div)
A3_E        out  5  destination tag of E
A3_M        out  5  destination tag of M
A3_W        out  5  destination tag of W
E_W         out  1  E instruction writes GRF
M_W         out  1  M instruction writes GRF
W_W         out  1  W instruction writes GRF
Tnew_E      out  2  remaining cycles until E result is forwardable
Tnew_M      out  2  remaining cycles until M result is forwardable
stall       out  1  hold PC and the D register this cycle
E_clr       out  1  load a bubble into the E register (equals stall)
md_busy     out  1  md unit busy counter non-zero

Behaviour:
Reset (reset=0, asynchronous):
- All A3_* = 0, all *_W = 0, Tnew_E = Tnew_M = 0.
- Internal md counter = 0. stall = 0 (no in-flight hazards).
- Reset asserted mid-stall clears everything immediately; the first cycle after release shows an empty pipeline.

Stage registers, updated every rising edge, never held (only D/PC freeze):
- W <= M: A3_W <= A3_M, W_W <= M_W. W Tnew is implicitly 0.
- M <= E: A3_M <= A3_E, M_W <= E_W, Tnew_M <= (Tnew_E==0) ? 0 : Tnew_E-1.
- E <= D when stall=0: A3_E <= D_A3, E_W <= D_W, Tnew_E <= D_Tnew.
- E <= bubble when stall=1: A3_E <= 0, E_W <= 0, Tnew_E <= 0.
- Tnew encodings used: jal = 0, ALU/lui = 1, load = 2.

Stall logic (combinational from current state and D inputs):
- haz_rs = D_use_rs && D_A1!=0 && ((D_A1==A3_E && E_W && Tnew_E > D_Tuse_rs) || (D_A1==A3_M && M_W && Tnew_M > D_Tuse_rs)).
- haz_rt: same form using D_A2 and D_Tuse_rt.
- haz_md = D_md_use && (md_busy || E_md_pending).
  - E_md_pending is a 1-bit register: it is set when a D_md_start instruction advances into E.
  - It is cleared on the next edge, or by a bubble.
- stall = haz_rs | haz_rt | haz_md. E_clr = stall.
- A destination tag of 0 never causes a hazard.
- W never causes a stall.

md counter:
- The edge on which E_md_pending=1 loads the counter with (mult ? MULT_LAT : DIV_LAT) using the latched div bit.
- Otherwise the counter decrements while non-zero. md_busy = (counter != 0).
- A new start cannot arrive while busy, because D_md_use stalls it.

Test Plan:
- Load-use:
  - lw $8 (D_Tnew=2), then next D addu reads rs=$8 with Tuse=1 -> stall=1 for exactly 1 cycle, E bubble has A3_E=0.
  - Then A3_M=8, Tnew_M=1 gives Tuse 1 ≥ 1, so no further stall.
- ALU chain: addu $5, then addu reading $5 with Tuse=1, Tnew_E=1 -> stall=0 every cycle. Tags flow A3_E=5 → A3_M=5 (Tnew_M=0) → A3_W=5.
- Branch on ALU result: beq reads $5 (Tuse=0) while addu $5 is in E with Tnew_E=1 -> stall 1 cycle, then 0 with Tnew_M=0.
- $0 and jal:
  - lw $0 followed by a reader of $0 -> no stall.
  - jal (A3=31, Tnew=0) followed by beq on $31 -> no stall, Tnew_E=0.
- mult latency:
  - mult enters E, then mfhi in D -> stall for 1+MULT_LAT = 6 cycles.
  - md_busy high for 5 cycles, then mfhi advances.
  - div gives 11 stall cycles.
- Reset mid-operation:
  - While a load-use stall is active and md_busy=1, drop reset -> stall, md_busy, all tags, *_W and Tnew drop to 0 asynchronously.
  - After release, no stall until new hazards enter.
